// File: rtl/adc_usb_packet_uploader_pkg.sv
// Shared definitions for the ADC-to-USB packet uploader: FSM encoding and the
// framing words also known to host software and the command interpreter.
package adc_usb_packet_uploader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_COUNT,
    S_DATA,
    S_CHECKSUM,
    S_TRAILER,
    S_FLUSH
  } state_e;

  localparam logic [15:0] DEFAULT_HEADER_WORD  = 16'hEB90;
  localparam logic [15:0] DEFAULT_TRAILER_WORD = 16'h90EB;
  localparam logic [15:0] DEFAULT_PAD_WORD     = 16'h0000;

  // Buffered samples carry zeros in [15:14]; the packet's channel tag goes there.
  function automatic logic [15:0] with_channel(input logic [1:0]  chn,
                                               input logic [15:0] raw);
    return raw | {chn, 14'b0};
  endfunction

endpackage

// File: rtl/adc_usb_packet_uploader_sample_sync_buffer.sv
// Single-clock sample FIFO with synchronous flush; absorbs ADC samples while
// the uploader writes framing words or the USB FIFO is full.
module sample_sync_buffer #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity, and
  // leaving the array reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_usb_packet_uploader.sv
// Frames ADC samples into fixed-length 16-bit packets for the USB data FIFO.
// Define ADC_UPLOAD_CHECKSUM_EN to append a modulo-2^16 checksum word before the trailer.
module adc_usb_packet_uploader
  import adc_usb_packet_uploader_pkg::*;
#(
  parameter int          ADC_WIDTH          = 12,
  parameter int          SAMPLES_PER_PACKET = 256,
  parameter logic [15:0] HEADER_WORD        = DEFAULT_HEADER_WORD,
  parameter logic [15:0] TRAILER_WORD       = DEFAULT_TRAILER_WORD,
  parameter logic [15:0] PAD_WORD           = DEFAULT_PAD_WORD,
  parameter int          BUF_AW             = 4,
  parameter int          CLEAR_HOLDOFF      = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_acq_enable,
  input  logic [1:0]           in_chn_select,
  input  logic                 in_adc_valid,
  input  logic [ADC_WIDTH-1:0] in_adc_data,
  input  logic                 in_clear_usb_fifo,
  input  logic                 in_usb_fifo_full,
  output logic                 out_to_usb_fifo_wr_en,
  output logic [15:0]          out_to_usb_fifo_din,
  output logic                 out_overflow,
  output logic                 out_busy
);

  localparam logic [15:0] LAST_DATA = 16'(SAMPLES_PER_PACKET - 1);
  localparam logic [15:0] LAST_HOLD = 16'(CLEAR_HOLDOFF - 1);
`ifdef ADC_UPLOAD_CHECKSUM_EN
  localparam state_e AFTER_DATA = S_CHECKSUM;
`else
  localparam state_e AFTER_DATA = S_TRAILER;
`endif

  state_e      state_q, state_d;
  logic [1:0]  chn_q, chn_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] din_q, din_d;
  logic        overflow_q, overflow_d;
`ifdef ADC_UPLOAD_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  logic        adc_push;
  logic        buf_pop;
  logic        buf_full;
  logic        buf_empty;
  logic [15:0] buf_din;
  logic [15:0] buf_dout;
  logic        emit;
  logic [15:0] word;

  assign adc_push = in_adc_valid && in_acq_enable && (state_q != S_FLUSH);
  assign buf_din  = {{(16-ADC_WIDTH){1'b0}}, in_adc_data};

  sample_sync_buffer #(
    .WIDTH (16),
    .AW    (BUF_AW)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (adc_push),
    .pop     (buf_pop),
    .flush   (in_clear_usb_fifo),
    .din     (buf_din),
    .dout    (buf_dout),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    chn_d      = chn_q;
    pkt_cnt_d  = pkt_cnt_q;
    data_cnt_d = data_cnt_q;
    hold_cnt_d = hold_cnt_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;
    overflow_d = overflow_q;
    buf_pop    = 1'b0;
    emit       = 1'b0;
    word       = '0;
`ifdef ADC_UPLOAD_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    if (in_clear_usb_fifo) begin
      state_d    = S_FLUSH;
      pkt_cnt_d  = '0;
      hold_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_acq_enable) begin
            chn_d   = in_chn_select;
            state_d = S_HEADER;
          end
        end
        S_HEADER: begin
          if (!in_usb_fifo_full) begin
            emit    = 1'b1;
            word    = HEADER_WORD;
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (!in_usb_fifo_full) begin
            emit       = 1'b1;
            word       = pkt_cnt_q;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            data_cnt_d = '0;
`ifdef ADC_UPLOAD_CHECKSUM_EN
            sum_d      = '0;
`endif
            state_d    = S_DATA;
          end
        end
        S_DATA: begin
          // Buffered samples always win over padding, so a stopped acquisition drains first.
          if (!in_usb_fifo_full && (!buf_empty || !in_acq_enable)) begin
            emit = 1'b1;
            if (!buf_empty) begin
              buf_pop = 1'b1;
              word    = with_channel(chn_q, buf_dout);
            end else begin
              word    = PAD_WORD;
            end
`ifdef ADC_UPLOAD_CHECKSUM_EN
            sum_d = sum_q + word;
`endif
            if (data_cnt_q == LAST_DATA) state_d = AFTER_DATA;
            else                         data_cnt_d = data_cnt_q + 16'd1;
          end
        end
        S_CHECKSUM: begin
`ifdef ADC_UPLOAD_CHECKSUM_EN
          if (!in_usb_fifo_full) begin
            emit    = 1'b1;
            word    = sum_q;
            state_d = S_TRAILER;
          end
`else
          state_d = S_IDLE;
`endif
        end
        S_TRAILER: begin
          if (!in_usb_fifo_full) begin
            emit = 1'b1;
            word = TRAILER_WORD;
            if (in_acq_enable) begin
              chn_d   = in_chn_select;
              state_d = S_HEADER;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          if (hold_cnt_q == LAST_HOLD) state_d = S_IDLE;
          else                         hold_cnt_d = hold_cnt_q + 16'd1;
        end
        default: state_d = S_IDLE;
      endcase

      if (adc_push && buf_full && !buf_pop) overflow_d = 1'b1;
      if (emit) begin
        wr_en_d = 1'b1;
        din_d   = word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      chn_q      <= '0;
      pkt_cnt_q  <= '0;
      data_cnt_q <= '0;
      hold_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chn_q      <= chn_d;
      pkt_cnt_q  <= pkt_cnt_d;
      data_cnt_q <= data_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ADC_UPLOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end
`endif

  assign out_to_usb_fifo_wr_en = wr_en_q;
  assign out_to_usb_fifo_din   = din_q;
  assign out_overflow          = overflow_q;
  assign out_busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_usb_packet_uploader.sv
// Scoreboard bench for adc_usb_packet_uploader: a packet-level model queues the
// expected word stream, a monitor compares every USB FIFO write against it.
module tb_adc_usb_packet_uploader;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_acq_enable;
  logic [1:0]  in_chn_select;
  logic        in_adc_valid;
  logic [11:0] in_adc_data;
  logic        in_clear_usb_fifo;
  logic        in_usb_fifo_full;
  logic        out_to_usb_fifo_wr_en;
  logic [15:0] out_to_usb_fifo_din;
  logic        out_overflow;
  logic        out_busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  logic        full_seen = 1'b0;

  // Packet-level reference model state.
  bit          m_en     = 1'b0;
  bit          m_in_pkt = 1'b0;
  int          m_n      = 0;
  logic [15:0] m_pkt    = 16'h0000;
  logic [15:0] m_sum    = 16'h0000;
  logic [1:0]  m_chn    = 2'b00;

  adc_usb_packet_uploader #(
    .SAMPLES_PER_PACKET (N)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .in_acq_enable         (in_acq_enable),
    .in_chn_select         (in_chn_select),
    .in_adc_valid          (in_adc_valid),
    .in_adc_data           (in_adc_data),
    .in_clear_usb_fifo     (in_clear_usb_fifo),
    .in_usb_fifo_full      (in_usb_fifo_full),
    .out_to_usb_fifo_wr_en (out_to_usb_fifo_wr_en),
    .out_to_usb_fifo_din   (out_to_usb_fifo_din),
    .out_overflow          (out_overflow),
    .out_busy              (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_start();
    m_chn = in_chn_select;
    exp_q.push_back(16'hEB90);
    exp_q.push_back(m_pkt);
    m_pkt    = m_pkt + 16'd1;
    m_n      = 0;
    m_sum    = 16'h0000;
    m_in_pkt = 1'b1;
  endtask

  task automatic m_word(input logic [15:0] w);
    exp_q.push_back(w);
    m_sum = m_sum + w;
    m_n++;
    if (m_n == N) begin
`ifdef ADC_UPLOAD_CHECKSUM_EN
      exp_q.push_back(m_sum);
`endif
      exp_q.push_back(16'h90EB);
      m_in_pkt = 1'b0;
      if (m_en) m_start();
    end
  endtask

  task automatic m_drop();
    m_en = 1'b0;
    for (int i = 0; i < N && m_in_pkt; i++) m_word(16'h0000);
  endtask

  task automatic push_sample(input logic [11:0] d);
    in_adc_valid = 1'b1;
    in_adc_data  = d;
    if (m_en) m_word({m_chn, 2'b00, d});
    tick();
    in_adc_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    check("drain_pending_words", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  always @(posedge clk) full_seen <= in_usb_fifo_full;

  // Monitor: every write is compared against the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && out_to_usb_fifo_wr_en) begin
      log_q.push_back(out_to_usb_fifo_din);
      check("write_while_full", 32'(full_seen), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got=%h expected=none at %0t", out_to_usb_fifo_din, $time);
      end else begin
        check("usb_word", 32'(out_to_usb_fifo_din), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] golden [9];
    golden = '{16'hEB90, 16'h0000, 16'h4001, 16'h4002, 16'h4003,
               16'h4004, 16'h90EB, 16'hEB90, 16'h0001};

    reset_n = 1'b0;
    in_acq_enable = 1'b0;
    in_chn_select = 2'b00;
    in_adc_valid = 1'b0;
    in_adc_data = '0;
    in_clear_usb_fifo = 1'b0;
    in_usb_fifo_full = 1'b0;
    repeat (3) tick();
    check("reset_wr_en", 32'(out_to_usb_fifo_wr_en), 32'd0);
    check("reset_din", 32'(out_to_usb_fifo_din), 32'd0);
    check("reset_overflow", 32'(out_overflow), 32'd0);
    check("reset_busy", 32'(out_busy), 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(out_busy), 32'd0);

    // Basic framing with fixed samples.
    in_chn_select = 2'b01;
    in_acq_enable = 1'b1;
    m_en = 1'b1;
    m_start();
    for (int i = 1; i <= 4; i++) begin
      repeat (2) tick();
      push_sample(12'(i));
    end
    wait_drain();
    check("log_len_first", 32'(log_q.size() >= 9), 32'd1);
    for (int i = 0; i < 9 && i < log_q.size(); i++)
      check("first_packets_literal", 32'(log_q[i]), 32'(golden[i]));

    // USB FIFO full for 20 cycles while samples keep arriving.
    push_sample(12'($urandom));
    tick();
    in_usb_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_sample(12'($urandom));
      repeat (3) tick();
    end
    in_usb_fifo_full = 1'b0;
    wait_drain();
    check("no_overflow_after_hold", 32'(out_overflow), 32'd0);

    // Samples every cycle with the FIFO full: only 16 fit, the 17th is dropped.
    in_usb_fifo_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_adc_valid = 1'b1;
      in_adc_data  = 12'($urandom);
      if (i < 16) m_word({m_chn, 2'b00, in_adc_data});
      tick();
      if (i == 15) check("overflow_before_17th", 32'(out_overflow), 32'd0);
      if (i == 16) check("overflow_at_17th", 32'(out_overflow), 32'd1);
    end
    in_adc_valid = 1'b0;
    repeat (2) tick();
    in_usb_fifo_full = 1'b0;
    wait_drain();
    check("overflow_sticky", 32'(out_overflow), 32'd1);

    // Clear mid-DATA: partial packet discarded, hold-off, counter restarts.
    for (int k = 0; k < 8 && m_n != 2; k++) begin
      push_sample(12'($urandom));
      repeat (2) tick();
    end
    wait_drain();
    in_clear_usb_fifo = 1'b1;
    exp_q.delete();
    m_pkt = 16'h0000;
    m_in_pkt = 1'b0;
    tick();
    in_clear_usb_fifo = 1'b0;
    check("flush_busy", 32'(out_busy), 32'd1);
    check("clear_overflow", 32'(out_overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("flush_no_write", 32'(out_to_usb_fifo_wr_en), 32'd0);
      tick();
    end
    m_start();
    wait_drain();
    check("counter_after_clear", 32'(log_q[log_q.size()-1]), 32'h0000);

    // Drop enable after the second sample: pad to length, trailer, back to idle.
    push_sample(12'($urandom));
    repeat (2) tick();
    push_sample(12'($urandom));
    wait_drain();
    in_acq_enable = 1'b0;
    m_drop();
    wait_drain();
    check("pad_word", 32'(log_q[log_q.size()-2]), 32'h0000);
    check("idle_after_drop", 32'(out_busy), 32'd0);

    // Randomised traffic with random back-pressure.
    in_chn_select = 2'($urandom);
    in_acq_enable = 1'b1;
    m_en = 1'b1;
    m_start();
    for (int s = 0; s < 14; s++) begin
      int gap;
      gap = int'($urandom_range(2, 5));
      for (int g = 0; g < gap; g++) begin
        in_usb_fifo_full = ($urandom_range(0, 3) == 0);
        tick();
      end
      push_sample(12'($urandom));
    end
    in_usb_fifo_full = 1'b0;
    wait_drain();
    in_acq_enable = 1'b0;
    m_drop();
    wait_drain();
    check("random_overflow", 32'(out_overflow), 32'd0);
    check("random_idle", 32'(out_busy), 32'd0);

    // Reset mid-packet returns everything to reset values.
    in_acq_enable = 1'b1;
    m_en = 1'b1;
    m_start();
    repeat (2) tick();
    push_sample(12'($urandom));
    reset_n = 1'b0;
    #1;
    check("midreset_wr_en", 32'(out_to_usb_fifo_wr_en), 32'd0);
    check("midreset_din", 32'(out_to_usb_fifo_din), 32'd0);
    check("midreset_busy", 32'(out_busy), 32'd0);
    exp_q.delete();
    m_en = 1'b0;
    in_acq_enable = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("after_reset_busy", 32'(out_busy), 32'd0);
    check("after_reset_no_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
